// File: rtl/fp_mul_booth_seq.sv
`default_nettype none
// ============================================================================
// Module      : fp_mul_booth_seq
// Description : Sequential radix-4 Booth significand multiplier for binary32,
//               one Booth digit per cycle, subnormal operands flushed to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_mul_booth_seq #(
    parameter int MAN_W = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [31:0]          fp_X,
    input  logic [31:0]          fp_Y,
    output logic                 busy,
    output logic                 valid,
    output logic [2*MAN_W-1:0]   frc_Z_full,
    output logic                 sign_Z,
    output logic                 flush
);

    localparam int Q_W    = MAN_W + 2;
    localparam int DIGITS = Q_W / 2;
    localparam int ACC_W  = 2 * MAN_W + 2;
    localparam int CNT_W  = $clog2(DIGITS + 1);
    localparam logic [CNT_W-1:0] C_LAST_DIGIT = CNT_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    // Multiplier with q[-1] at bit 0; shifted right two places per digit so the
    // current Booth triplet always sits in bits [2:0].
    logic [Q_W:0]       r_q;
    logic [ACC_W-1:0]   r_m_sh;
    logic [ACC_W-1:0]   r_acc;
    logic               r_sign_lat;
    logic               r_flush_lat;

    logic [MAN_W-1:0]   w_m;
    logic [Q_W-1:0]     w_q;
    logic               w_flush;
    logic [ACC_W-1:0]   w_pp;
    logic [ACC_W-1:0]   w_acc_next;

    always_comb begin
        w_m     = {|fp_X[30:23], fp_X[MAN_W-2:0]};
        w_q     = {2'b00, |fp_Y[30:23], fp_Y[MAN_W-2:0]};
        w_flush = (fp_X[30:23] == 8'd0) || (fp_Y[30:23] == 8'd0);
    end

    always_comb begin
        w_pp = '0;
        case (r_q[2:0])
            3'b001, 3'b010: w_pp = r_m_sh;
            3'b011:         w_pp = r_m_sh << 1;
            3'b100:         w_pp = -(r_m_sh << 1);
            3'b101, 3'b110: w_pp = -r_m_sh;
            default:        w_pp = '0;
        endcase
        w_acc_next = r_acc + w_pp;
    end

    assign busy = (r_state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_q         <= '0;
            r_m_sh      <= '0;
            r_acc       <= '0;
            r_sign_lat  <= 1'b0;
            r_flush_lat <= 1'b0;
            valid       <= 1'b0;
            frc_Z_full  <= '0;
            sign_Z      <= 1'b0;
            flush       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    valid <= 1'b0;
                    if (start) begin
                        r_state     <= ST_RUN;
                        r_cnt       <= '0;
                        r_q         <= {w_q, 1'b0};
                        r_m_sh      <= ACC_W'(w_m);
                        r_acc       <= '0;
                        r_sign_lat  <= fp_X[31] ^ fp_Y[31];
                        r_flush_lat <= w_flush;
                    end
                end
                ST_RUN: begin
                    r_acc  <= w_acc_next;
                    r_q    <= r_q >> 2;
                    r_m_sh <= r_m_sh << 2;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == C_LAST_DIGIT) begin
                        r_state    <= ST_DONE;
                        valid      <= 1'b1;
                        frc_Z_full <= r_flush_lat ? '0 : w_acc_next[2*MAN_W-1:0];
                        sign_Z     <= r_sign_lat;
                        flush      <= r_flush_lat;
                    end
                end
                ST_DONE: begin
                    valid   <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    valid   <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_mul_booth_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_mul_booth_seq
// Description : Self-checking bench for fp_mul_booth_seq against a plain
//               integer-multiply model of the significand product.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_mul_booth_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] fp_X;
    logic [31:0] fp_Y;
    logic        busy;
    logic        valid;
    logic [47:0] frc_Z_full;
    logic        sign_Z;
    logic        flush;

    int n_cmp = 0;
    int n_err = 0;

    fp_mul_booth_seq #(.MAN_W(24)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .fp_X       (fp_X),
        .fp_Y       (fp_Y),
        .busy       (busy),
        .valid      (valid),
        .frc_Z_full (frc_Z_full),
        .sign_Z     (sign_Z),
        .flush      (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [47:0] frc;
        logic        sgn;
        logic        fl;
    } vec_t;

    localparam int NVEC = 10;
    vec_t vecs[NVEC];

    function automatic logic [47:0] ref_frac(input logic [31:0] x, input logic [31:0] y);
        longint unsigned mx, my;
        if (x[30:23] == 8'd0 || y[30:23] == 8'd0) return 48'd0;
        mx = {40'd0, 1'b1, x[22:0]};
        my = {40'd0, 1'b1, y[22:0]};
        return 48'(mx * my);
    endfunction

    function automatic logic [31:0] rand_normal();
        logic [7:0]  e;
        logic [22:0] m;
        logic        s;
        s = 1'($urandom_range(0, 1));
        e = 8'($urandom_range(1, 254));
        m = 23'($urandom);
        return {s, e, m};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 40 && busy; k++) tick();
        if (busy) check("wait_idle_timeout", 64'(busy), 64'd0);
    endtask

    // Single operation: pulse start, expect valid exactly 13 edges later.
    task automatic run_op(input string name, input logic [31:0] x, input logic [31:0] y,
                          input logic [47:0] efrc, input logic esgn, input logic efl);
        int lat;
        wait_idle();
        fp_X  = x;
        fp_Y  = y;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (valid) begin
                lat = k;
                break;
            end
        end
        check({name, "_latency"}, 64'(lat), 64'd13);
        check({name, "_frc"}, 64'(frc_Z_full), 64'(efrc));
        check({name, "_sign"}, 64'(sign_Z), 64'(esgn));
        check({name, "_flush"}, 64'(flush), 64'(efl));
        check({name, "_acc_hi"}, 64'(dut.r_acc[49:48]), 64'd0);
        tick();
        check({name, "_valid_one_cycle"}, 64'(valid), 64'd0);
    endtask

    initial begin
        int nv;
        logic [47:0] got;
        logic [31:0] bx, by;

        vecs[0] = '{32'h40400000, 32'h40400000, 48'h900000000000, 1'b0, 1'b0};
        vecs[1] = '{32'h3FFFFFFF, 32'hBFFFFFFF, 48'hFFFFFE000001, 1'b1, 1'b0};
        vecs[2] = '{32'h00400000, 32'h3F800000, 48'h000000000000, 1'b0, 1'b1};
        vecs[3] = '{32'h3F800000, 32'h3F800000, 48'h400000000000, 1'b0, 1'b0};
        for (int i = 4; i < NVEC; i++) begin
            vecs[i].x = rand_normal();
            vecs[i].y = rand_normal();
            if (i == NVEC - 1) vecs[i].y[30:23] = 8'd0;
            vecs[i].frc = ref_frac(vecs[i].x, vecs[i].y);
            vecs[i].sgn = vecs[i].x[31] ^ vecs[i].y[31];
            vecs[i].fl  = (vecs[i].x[30:23] == 8'd0) || (vecs[i].y[30:23] == 8'd0);
        end

        rst_n = 1'b0;
        start = 1'b0;
        fp_X  = '0;
        fp_Y  = '0;
        tick();
        tick();
        check("reset_outputs", {11'd0, busy, valid, sign_Z, flush, frc_Z_full}, 64'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < NVEC; i++)
            run_op($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].frc, vecs[i].sgn, vecs[i].fl);

        // start during RUN must be ignored
        wait_idle();
        fp_X  = 32'h3F800000;
        fp_Y  = 32'h3F800000;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        fp_X  = 32'h40400000;
        start = 1'b1;
        tick();
        start = 1'b0;
        nv = 0;
        got = '0;
        for (int k = 0; k < 40; k++) begin
            if (valid) begin
                nv++;
                if (nv == 1) got = frc_Z_full;
            end
            tick();
        end
        check("busy_single_valid", 64'(nv), 64'd1);
        check("busy_frc", 64'(got), 64'h400000000000);

        // reset mid-operation
        wait_idle();
        fp_X  = 32'h40400000;
        fp_Y  = 32'h40400000;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        rst_n = 1'b0;
        #1;
        check("midreset_outputs", {11'd0, busy, valid, sign_Z, flush, frc_Z_full}, 64'd0);
        nv = 0;
        for (int k = 0; k < 2; k++) begin
            tick();
            if (valid) nv++;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (valid) nv++;
        end
        check("midreset_no_valid", 64'(nv), 64'd0);
        run_op("after_reset", 32'h3F800000, 32'h3F800000, 48'h400000000000, 1'b0, 1'b0);

        // back-to-back with start held high
        wait_idle();
        bx = rand_normal();
        by = rand_normal();
        fp_X  = bx;
        fp_Y  = by;
        start = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            int lat;
            lat = 0;
            for (int k = 1; k <= 20; k++) begin
                tick();
                if (valid) begin
                    lat = k;
                    break;
                end
            end
            check($sformatf("b2b%0d_latency", i), 64'(lat), 64'd13);
            check($sformatf("b2b%0d_frc", i), 64'(frc_Z_full), 64'(ref_frac(bx, by)));
            check($sformatf("b2b%0d_sign", i), 64'(sign_Z), 64'(bx[31] ^ by[31]));
            bx = rand_normal();
            by = rand_normal();
            fp_X = bx;
            fp_Y = by;
            tick();
            check($sformatf("b2b%0d_idle_gap", i), 64'({busy, valid}), 64'd0);
            tick();
        end
        start = 1'b0;
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
